// File: rtl/io_in_pkg.sv
// Shared constants for the memory-mapped switch/button input port.
package io_in_pkg;
    localparam int N_SW  = 16;
    localparam int N_BTN = 4;

    localparam logic [2:0] OFF_SW   = 3'd0;
    localparam logic [2:0] OFF_BTN  = 3'd1;
    localparam logic [2:0] OFF_EV   = 3'd2;
    localparam logic [2:0] OFF_STAT = 3'd3;
    localparam logic [2:0] OFF_MASK = 3'd4;
endpackage

// File: rtl/io_in_port_if.sv
// CPU bus as seen by the input port: master is the CPU, slave is the peripheral.
interface io_in_port_if;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        hit;
    logic [15:0] rdata;
    logic        ready;

    modport master (output req, we, addr, wdata, input hit, rdata, ready);
    modport slave  (input req, we, addr, wdata, output hit, rdata, ready);
endinterface

// File: rtl/io_debounce.sv
// Two-flop synchroniser plus tick-gated two-sample agreement debounce.
// Latency: 2 sync cycles plus two ticks; no backpressure.
module io_debounce #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tick,
    input  logic [W-1:0] i_raw,
    output logic [W-1:0] o_deb
);
    logic [W-1:0] r_s1;
    logic [W-1:0] r_s2;
    logic [W-1:0] r_sample;
    logic [W-1:0] r_deb;
    logic [W-1:0] w_agree;

    assign w_agree = ~(r_s2 ^ r_sample);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1     <= '0;
            r_s2     <= '0;
            r_sample <= '0;
            r_deb    <= '0;
        end else begin
            r_s1 <= i_raw;
            r_s2 <= r_s1;
            if (tick) begin
                r_sample <= r_s2;
                // A bit only moves once two consecutive samples agree on it.
                r_deb    <= (w_agree & r_s2) | (~w_agree & r_deb);
            end
        end
    end

    assign o_deb = r_deb;
endmodule

// File: rtl/io_in_port.sv
// Memory-mapped switch/button input port with sticky press flags; optional
// MASK register and interrupt when IO_IN_IRQ_EN is defined.
module io_in_port
    import io_in_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR  = 16'hFF00,
    parameter int          DEB_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             rst_n,
    io_in_port_if.slave      bus,
    input  logic [N_SW-1:0]  sw,
    input  logic [N_BTN-1:0] btn,
    output logic             irq
);
    localparam int CNT_W = $clog2(DEB_CYCLES);

    logic [CNT_W-1:0] r_cnt;
    logic             w_tick;
    logic [N_SW-1:0]  w_sw_deb;
    logic [N_BTN-1:0] w_btn_deb;
    logic [N_BTN-1:0] r_btn_prev;
    logic [N_BTN-1:0] w_press;
    logic [N_BTN-1:0] r_ev;
    logic [N_BTN-1:0] w_ev_clr;
    logic [N_BTN-1:0] w_mask;
    logic             w_acc;
    logic [15:0]      w_rd;
    logic [15:0]      r_rdata;
    logic             r_ready;
    logic             w_unused;

    assign w_unused = &{1'b0, bus.wdata[15:N_BTN]};

    assign bus.hit = (bus.addr[15:3] == BASE_ADDR[15:3]);
    assign w_acc   = bus.req & bus.hit;
    assign w_tick  = (r_cnt == CNT_W'(DEB_CYCLES - 1));
    assign w_press = w_btn_deb & ~r_btn_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
        end
    end

    io_debounce #(.W(N_SW)) u_sw_deb (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (w_tick),
        .i_raw (sw),
        .o_deb (w_sw_deb)
    );

    io_debounce #(.W(N_BTN)) u_btn_deb (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (w_tick),
        .i_raw (btn),
        .o_deb (w_btn_deb)
    );

    always_comb begin
        w_ev_clr = '0;
        if (w_acc && bus.addr[2:0] == OFF_EV) begin
            w_ev_clr = bus.we ? bus.wdata[N_BTN-1:0] : '1;
        end
    end

    always_comb begin
        w_rd = '0;
        case (bus.addr[2:0])
            OFF_SW:   w_rd = w_sw_deb;
            OFF_BTN:  w_rd = {12'b0, w_btn_deb};
            OFF_EV:   w_rd = {12'b0, r_ev};
            OFF_STAT: w_rd = {15'b0, |r_ev};
            OFF_MASK: w_rd = {12'b0, w_mask};
            default:  w_rd = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_prev <= '0;
            r_ev       <= '0;
            r_rdata    <= '0;
            r_ready    <= 1'b0;
        end else begin
            r_btn_prev <= w_btn_deb;
            // A press in the clearing cycle wins so no event is lost.
            r_ev       <= (r_ev & ~w_ev_clr) | w_press;
            r_ready    <= w_acc;
            if (w_acc) begin
                r_rdata <= bus.we ? 16'h0000 : w_rd;
            end
        end
    end

    assign bus.rdata = r_rdata;
    assign bus.ready = r_ready;

`ifdef IO_IN_IRQ_EN
    logic [N_BTN-1:0] r_mask;
    logic             r_irq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask <= '0;
            r_irq  <= 1'b0;
        end else begin
            if (w_acc && bus.we && bus.addr[2:0] == OFF_MASK) begin
                r_mask <= bus.wdata[N_BTN-1:0];
            end
            r_irq <= |(r_ev & r_mask);
        end
    end

    assign w_mask = r_mask;
    assign irq    = r_irq;
`else
    assign w_mask = '0;
    assign irq    = 1'b0;
`endif
endmodule
